// File: rtl/mux_32_8_pkg.sv
// Shared definitions for the 32-to-8 serializer and its 8-to-32 reassembler.
package mux_32_8_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;

  // Byte value placed on the lane whenever no valid byte is present.
  localparam logic [BYTE_W-1:0] IDLE_BYTE_DEFAULT = 8'h00;

  // Byte counter width; holds 0..BYTES_PER_WORD-1.
  localparam int CNT_W = 2;

  // Count loaded with byte0: bytes still to emit after the first one.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_WORD - 1);

  // Line states, derived from valid_out rather than held in a separate register.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Select byte idx of a word, MSB first (idx 0 = w[31:24]).
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input logic [CNT_W-1:0]  idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mux_32_8_if.sv
// Word-side handshake plus byte-lane outputs of the serializer.
interface mux_32_8_if;
  import mux_32_8_pkg::*;

  logic [WORD_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  logic [BYTE_W-1:0] data_out;
  logic              valid_out;
  logic              sop_out;

  // The serializer itself.
  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_out,
    output valid_out,
    output sop_out
  );

  // The producer / byte-lane consumer around it.
  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_out,
    input  valid_out,
    input  sop_out
  );

endinterface

// File: rtl/mux_32_8_word_hold_reg.sv
// Single-entry holding register with a valid flag; load wins over clear.
module word_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  // Next-state: capture d on load, drop the flag on clear, else hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = d;
      valid_d = 1'b1;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset discards any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/mux_32_8.sv
// 32-bit word to MSB-first byte stream serializer with a one-word holding stage.
module mux_32_8
  import mux_32_8_pkg::*;
#(
  parameter logic [BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic       clk_4f,
  input  logic       reset_L,
  mux_32_8_if.slave  bus,
  output logic       idle_out
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              sop_out_q, sop_out_d;

  logic [WORD_W-1:0] hold_word;
  logic              hold_v;
  logic              hold_load;
  logic              hold_clear;

  logic              accept;
  logic              more_bytes;
  logic [0:0]        state;
  logic [CNT_W-1:0]  next_idx;

  // Ready depends only on the holding stage, never on valid_in.
  assign bus.ready_out = reset_L && !hold_v;
  assign accept        = bus.valid_in && bus.ready_out;

  assign state      = valid_out_q ? ST_SEND : ST_IDLE;
  assign more_bytes = (state == ST_SEND) && (cnt_q != '0);

  // Index of the byte following the current one: (3 - cnt) + 1.
  assign next_idx = LAST_CNT - (cnt_q - 1'b1);

  word_hold_reg #(
    .W (WORD_W)
  ) u_hold (
    .clk   (clk_4f),
    .rst_n (reset_L),
    .load  (hold_load),
    .clear (hold_clear),
    .d     (bus.data_in),
    .q     (hold_word),
    .valid (hold_v)
  );

  // Next-state: continue the active word, else start the held word, else bypass, else idle.
  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    sop_out_d   = 1'b0;
    hold_load   = 1'b0;
    hold_clear  = 1'b0;

    if (more_bytes) begin
      data_out_d = word_byte(shreg_q, next_idx);
      cnt_d      = cnt_q - 1'b1;
      hold_load  = accept;
    end else if (hold_v) begin
      // Held word goes first; a new word may refill the hold in the same edge.
      shreg_d     = hold_word;
      data_out_d  = word_byte(hold_word, 2'd0);
      cnt_d       = LAST_CNT;
      valid_out_d = 1'b1;
      sop_out_d   = 1'b1;
      hold_load   = accept;
      hold_clear  = !accept;
    end else if (accept) begin
      // Line free and nothing pending: skip the hold stage entirely.
      shreg_d     = bus.data_in;
      data_out_d  = word_byte(bus.data_in, 2'd0);
      cnt_d       = LAST_CNT;
      valid_out_d = 1'b1;
      sop_out_d   = 1'b1;
    end else begin
      valid_out_d = 1'b0;
      data_out_d  = IDLE_BYTE;
    end
  end

  // Serializer state registers; reset abandons any partial word.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      shreg_q     <= '0;
      cnt_q       <= '0;
      data_out_q  <= IDLE_BYTE;
      valid_out_q <= 1'b0;
      sop_out_q   <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      sop_out_q   <= sop_out_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.sop_out   = sop_out_q;

  // Idle only when nothing is on the line and nothing is waiting.
  assign idle_out = !valid_out_q && !hold_v;

endmodule

// File: tb/tb_mux_32_8.sv
// Directed and loopback checks for the mux_32_8 serializer.
module tb_mux_32_8;
  import mux_32_8_pkg::*;

  logic clk_4f = 1'b0;
  logic reset_L;
  logic idle_out;

  mux_32_8_if bus ();

  mux_32_8 #(
    .IDLE_BYTE (8'h00)
  ) dut (
    .clk_4f   (clk_4f),
    .reset_L  (reset_L),
    .bus      (bus),
    .idle_out (idle_out)
  );

  always #5 clk_4f = ~clk_4f;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic check_byte(input string tag, input logic [7:0] b, input logic sop);
    check_val({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
    check_val({tag, "_data"},  32'(bus.data_out),  32'(b));
    check_val({tag, "_sop"},   32'(bus.sop_out),   32'(sop));
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_valid"}, 32'(bus.valid_out), 32'd0);
    check_val({tag, "_data"},  32'(bus.data_out),  32'h00);
    check_val({tag, "_sop"},   32'(bus.sop_out),   32'd0);
    check_val({tag, "_idle"},  32'(idle_out),      32'd1);
  endtask

  // Producer offers three words back-to-back, holding each until accepted.
  task automatic stream3(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2);
    logic [31:0] w [3];
    logic [31:0] tmp;
    int          idx;
    bit          acc;
    w[0] = w0; w[1] = w1; w[2] = w2;
    idx  = 0;
    for (int cyc = 0; cyc < 13; cyc++) begin
      bus.valid_in = (idx < 3);
      bus.data_in  = (idx < 3) ? w[idx] : 32'h0;
      acc = bus.valid_in && bus.ready_out;
      step();
      if (acc) idx++;
      if (cyc < 12) begin
        tmp = w[cyc / 4] >> (24 - 8 * (cyc % 4));
        check_byte($sformatf("%s_b%0d", tag, cyc), tmp[7:0], (cyc % 4) == 0);
      end else begin
        check_idle({tag, "_end"});
      end
      if (cyc == 1) check_val({tag, "_ready_c1"}, 32'(bus.ready_out), 32'd0);
      if (cyc == 4) check_val({tag, "_ready_c4"}, 32'(bus.ready_out), 32'd1);
      if (cyc == 5) check_val({tag, "_ready_c5"}, 32'(bus.ready_out), 32'd0);
      $display("[TB] %s cycle %0d data_out=%h valid=%0d sop=%0d ready=%0d", tag, cyc,
               bus.data_out, bus.valid_out, bus.sop_out, bus.ready_out);
    end
    bus.valid_in = 1'b0;
    check_val({tag, "_accepted"}, 32'(idx), 32'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      check_val({tag, "_no_dup"}, 32'(bus.valid_out), 32'd0);
    end
  endtask

  logic [31:0] sent_q [$];
  logic [31:0] rx_word;
  logic [31:0] exp_word;
  int          rx_n;
  int          sent_cnt;
  int          recv_cnt;
  bit          acc;

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 32'h0;
    reset_L      = 1'b1;
    #1 reset_L   = 1'b0;
    #1;
    check_val("rst_data",  32'(bus.data_out),  32'h00);
    check_val("rst_valid", 32'(bus.valid_out), 32'd0);
    check_val("rst_sop",   32'(bus.sop_out),   32'd0);
    check_val("rst_ready", 32'(bus.ready_out), 32'd0);
    repeat (2) @(posedge clk_4f);
    @(negedge clk_4f);
    reset_L = 1'b1;
    #1;
    check_val("post_rst_ready", 32'(bus.ready_out), 32'd1);
    check_val("post_rst_idle",  32'(idle_out),      32'd1);

    // Single word, then back to idle.
    bus.valid_in = 1'b1;
    bus.data_in  = 32'hDEADBEEF;
    step();
    bus.valid_in = 1'b0;
    check_byte("single_b0", 8'hDE, 1'b1);
    check_val("single_busy", 32'(idle_out), 32'd0);
    step(); check_byte("single_b1", 8'hAD, 1'b0);
    step(); check_byte("single_b2", 8'hBE, 1'b0);
    step(); check_byte("single_b3", 8'hEF, 1'b0);
    step(); check_idle("single_end");
    $display("[TB] single word DEADBEEF done");

    // Two words exactly four cycles apart: continuous byte stream.
    begin
      logic [7:0] exp_b [8];
      exp_b = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
      for (int k = 0; k < 8; k++) begin
        if (k == 0) begin bus.valid_in = 1'b1; bus.data_in = 32'h01234567; end
        if (k == 4) begin bus.valid_in = 1'b1; bus.data_in = 32'h89ABCDEF; end
        step();
        bus.valid_in = 1'b0;
        check_byte($sformatf("b2b_b%0d", k), exp_b[k], (k % 4) == 0);
      end
      step(); check_idle("b2b_end");
      $display("[TB] back-to-back 01234567/89ABCDEF done");
    end

    // Flooding producer, and a held word under back-pressure.
    stream3("flood", 32'h11111111, 32'h22222222, 32'h33333333);
    stream3("bp", 32'h12345678, 32'h9ABCDEF0, 32'hCAFEF00D);

    // Asynchronous reset in the middle of a word.
    bus.valid_in = 1'b1;
    bus.data_in  = 32'hA5A55A5A;
    step();
    bus.valid_in = 1'b0;
    check_byte("rstmid_b0", 8'hA5, 1'b1);
    step();
    check_byte("rstmid_b1", 8'hA5, 1'b0);
    #3 reset_L = 1'b0;
    #1;
    check_val("rstmid_data",  32'(bus.data_out),  32'h00);
    check_val("rstmid_valid", 32'(bus.valid_out), 32'd0);
    check_val("rstmid_ready", 32'(bus.ready_out), 32'd0);
    @(negedge clk_4f);
    reset_L = 1'b1;
    #1;
    check_val("rstmid_idle", 32'(idle_out), 32'd1);
    bus.valid_in = 1'b1;
    bus.data_in  = 32'h0F0F0F0F;
    step();
    bus.valid_in = 1'b0;
    check_byte("rstmid_n0", 8'h0F, 1'b1);
    step(); check_byte("rstmid_n1", 8'h0F, 1'b0);
    step(); check_byte("rstmid_n2", 8'h0F, 1'b0);
    step(); check_byte("rstmid_n3", 8'h0F, 1'b0);
    step(); check_idle("rstmid_end");
    $display("[TB] reset mid-word then 0F0F0F0F done");

    // Loopback: 100 random words, reassembled from the byte lane.
    rx_n     = 0;
    sent_cnt = 0;
    recv_cnt = 0;
    rx_word  = 32'h0;
    for (int cyc = 0; cyc < 2000 && recv_cnt < 100; cyc++) begin
      if (!bus.valid_in && sent_cnt < 100 && $urandom_range(0, 3) != 0) begin
        bus.valid_in = 1'b1;
        bus.data_in  = $urandom;
      end
      acc = bus.valid_in && bus.ready_out;
      step();
      if (acc) begin
        sent_q.push_back(bus.data_in);
        sent_cnt++;
        bus.valid_in = 1'b0;
      end
      if (bus.valid_out) begin
        if (bus.sop_out) begin
          check_val("lb_sop_align", 32'(rx_n % 4), 32'd0);
          rx_word = {24'h0, bus.data_out};
          rx_n    = 1;
        end else begin
          rx_word = {rx_word[23:0], bus.data_out};
          rx_n++;
        end
        if (rx_n == 4) begin
          exp_word = (sent_q.size() > 0) ? sent_q.pop_front() : 32'hxxxxxxxx;
          check_val($sformatf("lb_word%0d", recv_cnt), rx_word, exp_word);
          $display("[TB] loopback word %0d got %h expected %h", recv_cnt, rx_word, exp_word);
          recv_cnt++;
        end
      end
    end
    bus.valid_in = 1'b0;
    check_val("lb_count", 32'(recv_cnt), 32'd100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mux_32_8.md
Name: mux_32_8

Overview:
- Transmit-side serializer: takes one 32-bit word with valid/ready handshake and emits it as four consecutive bytes, MSB first, with a byte-valid strobe.
- Runs on the 4f clock, so a word sustained at f rate leaves as a continuous byte stream at 4f.
- Output feeds the byte lane that demux_8_32 reassembles. A word pushed here reappears intact at the demux output.
- One-word holding register decouples the producer, so back-to-back words stream with no idle gap.

Parameters:
- IDLE_BYTE, 8'h00, value driven on data_out whenever valid_out=0.

Ports:
- clk_4f  input  1  single clock, rising-edge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  32  word to transmit; byte0 = data_in[31:24], byte3 = data_in[7:0].
- valid_in  input  1  data_in valid; word accepted on an edge where valid_in && ready_out.
- ready_out  output  1  block can accept a word this cycle.
- data_out  output  8  current byte, registered.
- valid_out  output  1  data_out holds a valid byte, registered.
- sop_out  output  1  high with byte0 of each word, registered.
- idle_out  output  1  no byte in flight and holding register empty, combinational from state.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - Outputs: data_out=IDLE_BYTE, valid_out=0, sop_out=0, ready_out=0.
  - Internal: shift register, remaining count cnt and hold_v cleared.
  - Any in-flight or held word is discarded; no partial word resumes.
- After reset release: ready_out=1 and idle_out=1 from the first cycle.
- Registers:
  - shreg[31:0]: active word.
  - cnt[1:0]: bytes of shreg still to emit after the current byte.
  - hold[31:0], hold_v: pending word.
- ready_out = reset_L && !hold_v. It never depends on valid_in (no combinational loop).
- accept = valid_in && ready_out.
- States, derived from valid_out and cnt:
  - IDLE: valid_out=0.
  - SEND: valid_out=1. Byte index = 3-cnt.
- Edge rules, first match wins:
  1. SEND with cnt>0: data_out <= next byte of shreg (MSB first); cnt <= cnt-1; sop_out <= 0. If accept: hold <= data_in, hold_v <= 1.
  2. Last byte done or IDLE, with hold_v=1: shreg <= hold; data_out <= hold[31:24]; cnt <= 3; valid_out <= 1; sop_out <= 1. If accept: hold <= data_in, hold_v stays 1; else hold_v <= 0.
  3. Last byte done or IDLE, with hold_v=0 and accept: bypass. shreg <= data_in; data_out <= data_in[31:24]; cnt <= 3; valid_out <= 1; sop_out <= 1. hold_v stays 0.
  4. Otherwise: valid_out <= 0; sop_out <= 0; data_out <= IDLE_BYTE → IDLE.
- Latency: word accepted at edge N with the block empty → byte0 on data_out after edge N; bytes 1..3 after edges N+1..N+3.
- Throughput: one word per 4 cycles sustained.
  - Producer offering exactly one word every 4 cycles → valid_out stays high continuously; hold is used for at most 1 cycle.
  - Producer offering every cycle → hold fills; ready_out low until hold drains into shreg.
- Simultaneous accept and hold drain (rule 2): both allowed. Order preserved: held word is transmitted before the new one.
- valid_in while ready_out=0: ignored; the producer must hold the word.
- data_in is sampled only on accepted edges; X on data_in when not accepted must not propagate.
- Byte order invariant: concatenating the four bytes following an sop_out pulse reproduces the accepted word exactly.
- idle_out = !valid_out && !hold_v (valid_out high covers a word still in flight).

Decomposition:
- Shared package, common to mux_32_8 and demux_8_32:
  - BYTES_PER_WORD = 4.
  - WORD_W = 32, BYTE_W = 8.
  - IDLE_BYTE default.
- Sub-module: word_hold_reg (32-bit register with valid flag, load/clear, async active-low reset) for the holding stage.
- Shifter and counter stay in the top module.

Test Plan:
- Reset then single word: accept 32'hDEADBEEF at edge N → data_out DE,AD,BE,EF after edges N..N+3; sop_out high only with DE; valid_out low and data_out=IDLE_BYTE after N+4; idle_out back to 1.
- Back-to-back at f rate: 32'h01234567 then 32'h89ABCDEF, 4 cycles apart → 8 bytes 01..EF with valid_out continuous and sop_out on 01 and 89.
- Producer floods every cycle with words 32'h11111111, 22222222, 33333333 → ready_out drops after the second accept; bytes emitted strictly in order; no word lost or duplicated.
- Back-pressure: valid_in held high with 32'hCAFEF00D while ready_out=0 → accepted only once ready_out=1; transmitted exactly once.
- Reset mid-word: assert reset_L=0 after byte1 of 32'hA5A55A5A → data_out=IDLE_BYTE and valid_out=0 immediately (asynchronous); after release the next word 32'h0F0F0F0F streams cleanly with no leftover bytes.
- Loopback: 100 random words through mux_32_8 into demux_8_32 (valid_out → valid) → demux data_out matches the sent sequence word-for-word.
